gate_test_sequencer: RTL and testbench

//  Sequences one complete 2-input gate test: fetch stimulus and expected bytes from the shared

---
 rtl/gate_tester_pkg.sv | 32 +++
 rtl/sync_2ff.sv | 25 ++
 rtl/gate_test_sequencer.sv | 204 ++++++++++++++++++++
 tb/tb_gate_test_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_tester_pkg.sv
// Shared types and constants for the gate test sequencer.
package gate_tester_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH_S,
    FETCH_E,
    APPLY,
    SETTLE,
    SAMPLE,
    WRITE,
    FINISH
  } state_e;

  localparam logic MEM_RD = 1'b0;
  localparam logic MEM_WR = 1'b1;

  localparam logic [15:0] DEF_STIM_ADDR   = 16'h0008;
  localparam logic [15:0] DEF_EXP_ADDR    = 16'h0010;
  localparam logic [15:0] DEF_RESULT_ADDR = 16'h0000;

  // Mask covering the low n bits of a result/expected byte.
  function automatic logic [7:0] vec_mask(input int unsigned n);
    logic [7:0] m;
    m = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (i < n) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input bit.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // Shift the async input through two flops to settle metastability.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/gate_test_sequencer.sv
// Runs one 2-input gate test: fetch stimulus/expected bytes, drive each input pair onto the
// DUT pins, sample the synchronised DUT output after a settle delay, write back the result.
module gate_test_sequencer
  import gate_tester_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned NUM_VECTORS   = 4,
  parameter logic [15:0] STIM_ADDR     = DEF_STIM_ADDR,
  parameter logic [15:0] EXP_ADDR      = DEF_EXP_ADDR,
  parameter logic [15:0] RESULT_ADDR   = DEF_RESULT_ADDR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic [1:0]  dut_pins,
  input  logic        dut_out,
  output logic [7:0]  result,
  output logic        pass,
  output logic        busy,
  output logic        done
);

  localparam logic [1:0] LAST_IDX    = 2'(NUM_VECTORS - 1);
  localparam logic [7:0] VEC_MASK    = vec_mask(NUM_VECTORS);
  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES);

  state_e      state_q, state_d;
  logic [7:0]  stim_q, stim_d;
  logic [7:0]  exp_q, exp_d;
  logic [7:0]  result_q, result_d;
  logic        pass_q, pass_d;
  logic [1:0]  vec_idx_q, vec_idx_d;
  logic [7:0]  settle_q, settle_d;
  logic [1:0]  pins_q, pins_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        dut_sync;
  logic        acked;

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (dut_out),
    .q     (dut_sync)
  );

  // An ack only counts while our request is actually up.
  assign acked = req_q & mem_ack;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      stim_q    <= '0;
      exp_q     <= '0;
      result_q  <= '0;
      pass_q    <= 1'b0;
      vec_idx_q <= '0;
      settle_q  <= '0;
      pins_q    <= '0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      stim_q    <= stim_d;
      exp_q     <= exp_d;
      result_q  <= result_d;
      pass_q    <= pass_d;
      vec_idx_q <= vec_idx_d;
      settle_q  <= settle_d;
      pins_q    <= pins_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
    end
  end

  // Next-state logic. Memory phases raise req a cycle after entry, which gives the required
  // idle cycle between consecutive accesses, and drop it on the cycle after the ack.
  always_comb begin
    state_d   = state_q;
    stim_d    = stim_q;
    exp_d     = exp_q;
    result_d  = result_q;
    pass_d    = pass_q;
    vec_idx_d = vec_idx_q;
    settle_d  = settle_q;
    pins_d    = pins_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = FETCH_S;
          result_d  = '0;
          pass_d    = 1'b0;
          vec_idx_d = '0;
          settle_d  = '0;
        end
      end

      FETCH_S: begin
        if (acked) begin
          stim_d  = mem_rdata;
          req_d   = 1'b0;
          we_d    = 1'b0;
          addr_d  = '0;
          state_d = FETCH_E;
        end else begin
          req_d  = 1'b1;
          we_d   = MEM_RD;
          addr_d = STIM_ADDR;
        end
      end

      FETCH_E: begin
        if (acked) begin
          exp_d   = mem_rdata;
          req_d   = 1'b0;
          we_d    = 1'b0;
          addr_d  = '0;
          state_d = APPLY;
        end else begin
          req_d  = 1'b1;
          we_d   = MEM_RD;
          addr_d = EXP_ADDR;
        end
      end

      APPLY: begin
        pins_d   = stim_q[{vec_idx_q, 1'b0} +: 2];
        settle_d = SETTLE_LOAD;
        state_d  = SETTLE;
      end

      SETTLE: begin
        settle_d = settle_q - 8'd1;
        // <= guards against a zero load never terminating
        if (settle_q <= 8'd1) state_d = SAMPLE;
      end

      SAMPLE: begin
        result_d[vec_idx_q] = dut_sync;
        if (vec_idx_q == LAST_IDX) begin
          state_d = WRITE;
        end else begin
          vec_idx_d = vec_idx_q + 2'd1;
          state_d   = APPLY;
        end
      end

      WRITE: begin
        if (acked) begin
          req_d   = 1'b0;
          we_d    = 1'b0;
          addr_d  = '0;
          wdata_d = '0;
          pass_d  = ((result_q ^ exp_q) & VEC_MASK) == 8'h00;
          state_d = FINISH;
        end else begin
          req_d   = 1'b1;
          we_d    = MEM_WR;
          addr_d  = RESULT_ADDR;
          wdata_d = result_q;
        end
      end

      FINISH: begin
        pins_d  = 2'b00;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // Outputs come straight from registers so async reset clears them immediately.
  always_comb begin
    mem_req   = req_q;
    mem_we    = we_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    dut_pins  = pins_q;
    result    = result_q;
    pass      = pass_q;
    busy      = (state_q != IDLE);
    done      = (state_q == FINISH);
  end

endmodule

// File: tb/tb_gate_test_sequencer.sv
// Directed bench for gate_test_sequencer: default instance (a) and a 2-vector, 2-cycle
// settle instance (b), each with a simple memory responder and gate model.
module tb_gate_test_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   n_checks = 0;
  int   n_fail = 0;

  // Instance a signals
  logic        start_a, req_a, we_a, ack_a, pins_out_a, pass_a, busy_a, done_a;
  logic [15:0] addr_a;
  logic [7:0]  wdata_a, rdata_a, result_a;
  logic [1:0]  pins_a;
  // Instance b signals
  logic        start_b, req_b, we_b, ack_b, out_b, pass_b, busy_b, done_b;
  logic [15:0] addr_b;
  logic [7:0]  wdata_b, rdata_b, result_b;
  logic [1:0]  pins_b;

  logic [7:0] mem_a [0:31];
  logic [7:0] mem_b [0:31];
  int         lat_a = 0;
  int         gate_sel = 0;  // 0 AND, 1 XOR, 3 NAND

  assign rdata_a = mem_a[addr_a[4:0]];
  assign rdata_b = mem_b[addr_b[4:0]];
  assign pins_out_a = (gate_sel == 1) ? (pins_a[1] ^ pins_a[0]) :
                      (gate_sel == 3) ? ~(pins_a[1] & pins_a[0]) : (pins_a[1] & pins_a[0]);
  assign out_b = pins_b[1] | pins_b[0];

  gate_test_sequencer u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .mem_req(req_a), .mem_we(we_a),
    .mem_addr(addr_a), .mem_wdata(wdata_a), .mem_ack(ack_a), .mem_rdata(rdata_a),
    .dut_pins(pins_a), .dut_out(pins_out_a), .result(result_a), .pass(pass_a),
    .busy(busy_a), .done(done_a)
  );

  gate_test_sequencer #(.SETTLE_CYCLES(2), .NUM_VECTORS(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .mem_req(req_b), .mem_we(we_b),
    .mem_addr(addr_b), .mem_wdata(wdata_b), .mem_ack(ack_b), .mem_rdata(rdata_b),
    .dut_pins(pins_b), .dut_out(out_b), .result(result_b), .pass(pass_b),
    .busy(busy_b), .done(done_b)
  );

  // Memory responder / monitor for instance a (sole writer of its counters).
  int          wait_a = 0, stab_err = 0, acc_n = 0, wr_n = 0, done_n = 0, pin_n = 0;
  logic        in_req_a = 1'b0, cap_we = 1'b0, busy_prev_a = 1'b0;
  logic [15:0] cap_addr = '0, wr_addr = '0;
  logic [7:0]  cap_wdata = '0, wr_data = '0;
  logic [15:0] acc_addr [0:255];
  logic        acc_we [0:255];
  logic [1:0]  pin_log [0:7];

  initial ack_a = 1'b0;
  always @(negedge clk) begin
    if (req_a) begin
      if (!in_req_a) begin
        cap_addr = addr_a; cap_we = we_a; cap_wdata = wdata_a;
      end else if (addr_a !== cap_addr || we_a !== cap_we || (we_a && wdata_a !== cap_wdata)) begin
        stab_err++;
      end
    end
    in_req_a = req_a;
    if (!rst_n) begin
      ack_a = 1'b0; wait_a = 0;
    end else if (req_a && !ack_a) begin
      if (wait_a >= lat_a) begin
        ack_a = 1'b1; wait_a = 0;
        acc_addr[acc_n[7:0]] = addr_a; acc_we[acc_n[7:0]] = we_a; acc_n++;
        if (we_a) begin wr_n++; wr_data = wdata_a; wr_addr = addr_a; end
      end else begin
        wait_a++;
      end
    end else begin
      ack_a = 1'b0; wait_a = 0;
    end
    if (done_a) done_n++;
    if (busy_a && !busy_prev_a) pin_n = 0;
    if (busy_a && (pin_n == 0 || (pin_n < 8 && pins_a !== pin_log[pin_n-1]))) begin
      pin_log[pin_n] = pins_a; pin_n++;
    end
    busy_prev_a = busy_a;
  end

  // Responder / timing monitor for instance b (zero ack latency).
  int         cyc = 0, wr_n_b = 0, t_p01 = -1, t_p11 = -1, t_r0 = -1, t_r1 = -1;
  logic [7:0] wr_data_b = '0, res_prev_b = '0;
  logic [1:0] pins_prev_b = '0;

  initial ack_b = 1'b0;
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) ack_b = 1'b0;
    else if (req_b && !ack_b) begin
      ack_b = 1'b1;
      if (we_b) begin wr_n_b++; wr_data_b = wdata_b; end
    end else ack_b = 1'b0;
    if (pins_b !== pins_prev_b && pins_b == 2'b01) t_p01 = cyc;
    if (pins_b !== pins_prev_b && pins_b == 2'b11) t_p11 = cyc;
    if (result_b[0] && !res_prev_b[0]) t_r0 = cyc;
    if (result_b[1] && !res_prev_b[1]) t_r1 = cyc;
    pins_prev_b = pins_b;
    res_prev_b = result_b;
  end

  task automatic pulse_start_a();
    @(negedge clk) start_a = 1'b1;
    @(negedge clk) start_a = 1'b0;
  endtask

  task automatic wait_done_a(input int budget, output bit ok, output logic [7:0] res,
                             output logic ps);
    ok = 1'b0; res = '0; ps = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done_a) begin ok = 1'b1; res = result_a; ps = pass_a; break; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({req_a, we_a, addr_a, wdata_a, pins_a, result_a, pass_a, busy_a, done_a} !== '0) begin
      n_fail++; $display("FAIL reset_a: outputs not zero (req=%b pins=%b busy=%b res=%h)",
                         req_a, pins_a, busy_a, result_a);
    end
    n_checks++;
    if ({req_b, we_b, addr_b, wdata_b, pins_b, result_b, pass_b, busy_b, done_b} !== '0) begin
      n_fail++; $display("FAIL reset_b: outputs not zero (req=%b pins=%b busy=%b)",
                         req_b, pins_b, busy_b);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Runs one full test on instance a and checks result/pass/write-back.
  task automatic run_a(input string nm, input int gsel, input int lat, input logic [7:0] exp_res,
                       input logic exp_pass);
    bit ok; logic [7:0] res; logic ps; int wr0, dn0;
    gate_sel = gsel; lat_a = lat;
    wr0 = wr_n; dn0 = done_n;
    pulse_start_a();
    n_checks++;
    if (busy_a !== 1'b1) begin n_fail++; $display("FAIL %s_busy: got %b want 1", nm, busy_a); end
    wait_done_a(300, ok, res, ps);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL %s_timeout: no done within budget", nm); end
    n_checks++;
    if (res !== exp_res) begin
      n_fail++; $display("FAIL %s_result: got %h want %h", nm, res, exp_res);
    end
    n_checks++;
    if (ps !== exp_pass) begin n_fail++; $display("FAIL %s_pass: got %b want %b", nm, ps, exp_pass); end
    repeat (3) @(negedge clk);
    n_checks++;
    if (wr_n - wr0 !== 1) begin n_fail++; $display("FAIL %s_writes: got %0d want 1", nm, wr_n - wr0); end
    n_checks++;
    if (wr_data !== exp_res || wr_addr !== 16'h0000) begin
      n_fail++; $display("FAIL %s_wb: got %h@%h want %h@0000", nm, wr_data, wr_addr, exp_res);
    end
    n_checks++;
    if (done_n - dn0 !== 1) begin n_fail++; $display("FAIL %s_done_cnt: got %0d want 1", nm, done_n - dn0); end
    n_checks++;
    if (busy_a !== 1'b0 || pins_a !== 2'b00 || result_a !== exp_res || pass_a !== exp_pass) begin
      n_fail++; $display("FAIL %s_hold: busy=%b pins=%b res=%h pass=%b want 0 00 %h %b",
                         nm, busy_a, pins_a, result_a, pass_a, exp_res, exp_pass);
    end
  endtask

  task automatic test_and();
    run_a("and", 0, 0, 8'h08, 1'b1);
    n_checks++;
    if (pin_n !== 4 || pin_log[0] !== 2'b00 || pin_log[1] !== 2'b01 ||
        pin_log[2] !== 2'b10 || pin_log[3] !== 2'b11) begin
      n_fail++; $display("FAIL and_pins: got n=%0d %b %b %b %b want 00 01 10 11", pin_n,
                         pin_log[0], pin_log[1], pin_log[2], pin_log[3]);
    end
  endtask

  task automatic test_xor();
    run_a("xor", 1, 0, 8'h06, 1'b0);
  endtask

  task automatic test_ack_delay();
    int s0, a0;
    s0 = stab_err; a0 = acc_n;
    run_a("delay", 0, 5, 8'h08, 1'b1);
    n_checks++;
    if (stab_err - s0 !== 0) begin
      n_fail++; $display("FAIL delay_stable: got %0d unstable cycles want 0", stab_err - s0);
    end
    n_checks++;
    if (acc_n - a0 !== 3) begin n_fail++; $display("FAIL delay_count: got %0d want 3", acc_n - a0); end
    n_checks++;
    if (acc_addr[a0] !== 16'h0008 || acc_we[a0] !== 1'b0 ||
        acc_addr[a0+1] !== 16'h0010 || acc_we[a0+1] !== 1'b0 ||
        acc_addr[a0+2] !== 16'h0000 || acc_we[a0+2] !== 1'b1) begin
      n_fail++; $display("FAIL delay_seq: got %h/%b %h/%b %h/%b want 0008/0 0010/0 0000/1",
                         acc_addr[a0], acc_we[a0], acc_addr[a0+1], acc_we[a0+1],
                         acc_addr[a0+2], acc_we[a0+2]);
    end
  endtask

  task automatic test_back_to_back_start();
    int wr0, dn0, drops; bit got;
    gate_sel = 0; lat_a = 0;
    wr0 = wr_n; dn0 = done_n; drops = 0; got = 1'b0;
    pulse_start_a();
    for (int i = 0; i < 100 && pins_a !== 2'b01; i++) @(negedge clk);
    pulse_start_a();  // lands during SETTLE of vector 1
    for (int i = 0; i < 300; i++) begin
      if (busy_a !== 1'b1) drops++;
      if (done_a) begin got = 1'b1; start_a = 1'b1; break; end
      @(negedge clk);
    end
    @(negedge clk) start_a = 1'b0;
    n_checks++;
    if (!got) begin n_fail++; $display("FAIL restart_timeout: no done within budget"); end
    n_checks++;
    if (drops !== 0) begin n_fail++; $display("FAIL restart_busy: got %0d low cycles want 0", drops); end
    repeat (5) @(negedge clk);
    n_checks++;
    if (busy_a !== 1'b0) begin n_fail++; $display("FAIL restart_ignored: busy=%b want 0", busy_a); end
    n_checks++;
    if (wr_n - wr0 !== 1 || done_n - dn0 !== 1) begin
      n_fail++; $display("FAIL restart_once: writes=%0d dones=%0d want 1 1", wr_n - wr0, done_n - dn0);
    end
  endtask

  task automatic test_reset_mid();
    int wr0;
    gate_sel = 3; lat_a = 0;
    wr0 = wr_n;
    pulse_start_a();
    for (int i = 0; i < 100 && pins_a !== 2'b01; i++) @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (result_a !== 8'h01) begin
      n_fail++; $display("FAIL midrst_pre: got %h want 01", result_a);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({req_a, we_a, addr_a, wdata_a, pins_a, result_a, pass_a, busy_a, done_a} !== '0) begin
      n_fail++; $display("FAIL midrst_zero: pins=%b res=%h busy=%b req=%b want all 0",
                         pins_a, result_a, busy_a, req_a);
    end
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (wr_n - wr0 !== 0) begin n_fail++; $display("FAIL midrst_nowrite: got %0d want 0", wr_n - wr0); end
    run_a("postrst", 3, 0, 8'h07, 1'b0);
  endtask

  task automatic test_small_config();
    bit ok;
    ok = 1'b0;
    @(negedge clk) start_b = 1'b1;
    @(negedge clk) start_b = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done_b) begin ok = 1'b1; break; end
    end
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL small_timeout: no done within budget"); end
    n_checks++;
    if (result_b !== 8'h03 || pass_b !== 1'b1) begin
      n_fail++; $display("FAIL small_result: got %h/%b want 03/1", result_b, pass_b);
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if (wr_n_b !== 1 || wr_data_b !== 8'h03) begin
      n_fail++; $display("FAIL small_wb: got %0d x %h want 1 x 03", wr_n_b, wr_data_b);
    end
    n_checks++;
    if (t_p01 < 0 || t_p11 <= t_p01) begin
      n_fail++; $display("FAIL small_pins: t01=%0d t11=%0d want 01 before 11", t_p01, t_p11);
    end
    n_checks++;
    if (t_r0 - t_p01 !== 3 || t_r1 - t_p11 !== 3) begin
      n_fail++; $display("FAIL small_timing: got %0d,%0d cycles pin->result want 3,3",
                         t_r0 - t_p01, t_r1 - t_p11);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin mem_a[i] = 8'h00; mem_b[i] = 8'h00; end
    mem_a[8] = 8'hE4; mem_a[16] = 8'h08;
    mem_b[8] = 8'h0D; mem_b[16] = 8'h03;
    test_reset();
    test_and();
    test_xor();
    test_ack_delay();
    test_back_to_back_start();
    test_reset_mid();
    test_small_config();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
